// File: rtl/fir_mac_engine_if.sv
// Tap/coefficient/result bundle between the shift register, the host and the FIR MAC engine.
interface fir_mac_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int COEF_WIDTH = 16
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] pDataIn [0:NUM_REGS-1];
  logic                  sampleValid;
  logic                  coefWrEn;
  logic [ADDR_WIDTH-1:0] coefWrAddr;
  logic [COEF_WIDTH-1:0] coefWrData;
  logic                  busy;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataOutValid;
  logic                  overrun;

  modport master (
    output pDataIn, sampleValid, coefWrEn, coefWrAddr, coefWrData,
    input  busy, dataOut, dataOutValid, overrun
  );

  modport slave (
    input  pDataIn, sampleValid, coefWrEn, coefWrAddr, coefWrData,
    output busy, dataOut, dataOutValid, overrun
  );
endinterface

// File: rtl/fir_mac_engine.sv
// Serial FIR multiply-accumulate: snapshots the taps on a sample strobe, accumulates
// one tap per cycle against a writable coefficient bank, then scales and saturates.
module fir_mac_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int COEF_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_REGS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  fir_mac_engine_if.slave  bus
);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]         snap_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]         snap_d [NUM_REGS];
  logic signed [COEF_WIDTH-1:0]  coef_q [NUM_REGS];
  logic signed [COEF_WIDTH-1:0]  coef_d [NUM_REGS];
  logic                          busy_q, busy_d;
  logic [DATA_WIDTH-1:0]         data_out_q, data_out_d;
  logic                          data_out_valid_q, data_out_valid_d;
  logic                          overrun_q, overrun_d;

  logic signed [DATA_WIDTH:0]    tap_s;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_WIDTH-1:0]   res;
  logic                          accept;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    acc_d            = acc_q;
    snap_d           = snap_q;
    coef_d           = coef_q;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    overrun_d        = 1'b0;
    accept           = 1'b0;

    // Taps are unsigned, so a zero MSB is prepended before the signed multiply.
    tap_s = $signed({1'b0, snap_q[idx_q]});
    prod  = tap_s * coef_q[idx_q];
    res   = acc_q >>> FRAC_BITS;

    if (bus.coefWrEn && !busy_q && (bus.coefWrAddr <= LAST_IDX))
      coef_d[bus.coefWrAddr] = bus.coefWrData;

    case (state_q)
      IDLE: accept = bus.sampleValid;
      MAC: begin
        acc_d     = acc_q + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
        idx_d     = idx_q + 1'b1;
        overrun_d = bus.sampleValid;
        if (idx_q == LAST_IDX)
          state_d = OUT;
      end
      OUT: begin
        data_out_valid_d = 1'b1;
        state_d          = IDLE;
        accept           = bus.sampleValid;
        if (res[ACC_WIDTH-1])
          data_out_d = '0;
        else if (|res[ACC_WIDTH-2:DATA_WIDTH])
          data_out_d = '1;
        else
          data_out_d = res[DATA_WIDTH-1:0];
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      snap_d  = bus.pDataIn;
      acc_d   = '0;
      idx_d   = '0;
      state_d = MAC;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      acc_q            <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        snap_q[i] <= '0;
        coef_q[i] <= '0;
      end
      busy_q           <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      acc_q            <= acc_d;
      snap_q           <= snap_d;
      coef_q           <= coef_d;
      busy_q           <= busy_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      overrun_q        <= overrun_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.dataOut      = data_out_q;
  assign bus.dataOutValid = data_out_valid_q;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: table-driven coefficient/tap vectors plus
// hand-written overrun, write-lockout, back-to-back and reset-abort sequences.
module tb_fir_mac_engine;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int CW = 16;
  localparam int FB = 8;

  typedef int arr_t [NR];
  typedef struct {
    arr_t coef;
    arr_t tap;
    int   exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fir_mac_engine_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .COEF_WIDTH(CW)) bus ();

  fir_mac_engine #(
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .COEF_WIDTH(CW),
    .FRAC_BITS (FB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int passed     = 0;
  int total      = 0;
  int valid_seen = 0;
  int pushed     = 0;
  int exp_q [$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Advance one clock, sample #1 later, and score any emitted result.
  task automatic step();
    int e;
    @(posedge clk);
    #1;
    if (bus.dataOutValid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: got dataOutValid=1 (dataOut=%0d), required 0", bus.dataOut);
      end else begin
        e = exp_q.pop_front();
        check("dataOut", longint'(bus.dataOut), longint'(e));
      end
    end
  endtask

  function automatic arr_t fill(input int v);
    arr_t a;
    for (int i = 0; i < NR; i++) a[i] = v;
    return a;
  endfunction

  task automatic set_taps(input arr_t t);
    for (int i = 0; i < NR; i++) bus.pDataIn[i] = DW'(t[i]);
  endtask

  task automatic write_coefs(input arr_t c);
    for (int i = 0; i < NR; i++) begin
      bus.coefWrEn   = 1'b1;
      bus.coefWrAddr = 3'(i);
      bus.coefWrData = CW'(c[i]);
      step();
    end
    bus.coefWrEn = 1'b0;
  endtask

  task automatic expect_result(input int e);
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic run_taps(input arr_t t, input int e, input string tag);
    set_taps(t);
    bus.sampleValid = 1'b1;
    expect_result(e);
    step();
    bus.sampleValid = 1'b0;
    check({tag, "_busy_T"}, longint'(bus.busy), 1);
    for (int k = 1; k <= NR + 1; k++) begin
      step();
      if (k <= NR) begin
        check({tag, "_busy_mid"}, longint'(bus.busy), 1);
        check({tag, "_valid_early"}, longint'(bus.dataOutValid), 0);
      end
    end
    check({tag, "_valid_T9"}, longint'(bus.dataOutValid), 1);
    check({tag, "_busy_T9"}, longint'(bus.busy), 0);
    check({tag, "_drained"}, longint'(exp_q.size()), 0);
  endtask

  initial begin
    vec_t vecs [9];
    arr_t ramp;
    arr_t ramp2;
    arr_t sparse;

    bus.sampleValid = 1'b0;
    bus.coefWrEn    = 1'b0;
    bus.coefWrAddr  = '0;
    bus.coefWrData  = '0;
    set_taps(fill(0));
    ramp  = '{1, 2, 3, 4, 5, 6, 7, 8};
    ramp2 = '{2, 3, 4, 5, 6, 7, 8, 9};

    vecs[0].coef = fill(256);  vecs[0].tap = ramp;       vecs[0].exp = 36;
    vecs[1].coef = '{256, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].tap  = '{1000, 7, 7, 7, 7, 7, 7, 7};         vecs[1].exp = 1000;
    vecs[2].coef = fill(256);  vecs[2].tap = fill(65535); vecs[2].exp = 65535;
    vecs[3].coef = fill(-256); vecs[3].tap = fill(5);     vecs[3].exp = 0;
    vecs[4].coef = '{128, -64, 512, 0, 1, -1, 300, 10};
    vecs[4].tap  = '{100, 200, 300, 400, 500, 600, 700, 800}; vecs[4].exp = 1451;
    sparse = fill(0); sparse[1] = -1;
    vecs[5].coef = sparse;
    sparse = fill(0); sparse[1] = 10;
    vecs[5].tap  = sparse;                                vecs[5].exp = 0;
    vecs[6].coef = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[6].tap  = '{511, 0, 0, 0, 0, 0, 0, 0};           vecs[6].exp = 1;
    vecs[7].coef = '{256, 0, 0, 0, 0, 0, 0, 0};
    vecs[7].tap  = '{65535, 0, 0, 0, 0, 0, 0, 0};         vecs[7].exp = 65535;
    vecs[8].coef = '{257, 0, 0, 0, 0, 0, 0, 0};
    vecs[8].tap  = '{65535, 0, 0, 0, 0, 0, 0, 0};         vecs[8].exp = 65535;

    // Reset state, then a computation with the cleared coefficient bank.
    rst = 1'b0;
    step();
    step();
    check("rst_busy",    longint'(bus.busy), 0);
    check("rst_dataOut", longint'(bus.dataOut), 0);
    check("rst_valid",   longint'(bus.dataOutValid), 0);
    check("rst_overrun", longint'(bus.overrun), 0);
    rst = 1'b1;
    step();
    run_taps(ramp, 0, "zero_coef");

    for (int v = 0; v < 9; v++) begin
      write_coefs(vecs[v].coef);
      run_taps(vecs[v].tap, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Overrun and write lockout.
    write_coefs(fill(256));
    set_taps(ramp);
    bus.sampleValid = 1'b1;
    expect_result(36);
    step();                                   // T
    bus.sampleValid = 1'b0;
    step();                                   // T+1
    bus.coefWrEn   = 1'b1;
    bus.coefWrAddr = 3'd0;
    bus.coefWrData = '0;
    step();                                   // T+2, write ignored
    bus.coefWrEn    = 1'b0;
    bus.sampleValid = 1'b1;
    set_taps(fill(100));
    step();                                   // T+3, dropped sample
    check("overrun_pulse", longint'(bus.overrun), 1);
    bus.sampleValid = 1'b0;
    step();                                   // T+4
    check("overrun_single", longint'(bus.overrun), 0);
    for (int k = 5; k <= 9; k++) step();
    check("ovr_valid_T9", longint'(bus.dataOutValid), 1);
    check("ovr_drained", longint'(exp_q.size()), 0);
    for (int k = 0; k < 3; k++) step();
    check("ovr_no_restart", longint'(bus.busy), 0);
    run_taps(ramp, 36, "lockout");

    // Back-to-back via OUT, then reset abort of a third computation.
    set_taps(ramp);
    bus.sampleValid = 1'b1;
    expect_result(36);
    step();                                   // T
    bus.sampleValid = 1'b0;
    for (int k = 1; k <= NR; k++) step();
    set_taps(ramp2);
    bus.sampleValid = 1'b1;
    expect_result(44);
    step();                                   // T+9
    check("b2b_valid1", longint'(bus.dataOutValid), 1);
    check("b2b_busy",   longint'(bus.busy), 1);
    check("b2b_no_ovr", longint'(bus.overrun), 0);
    bus.sampleValid = 1'b0;
    for (int k = 1; k <= NR; k++) step();
    set_taps(ramp);
    bus.sampleValid = 1'b1;
    step();                                   // T+18 = T'
    check("b2b_valid2", longint'(bus.dataOutValid), 1);
    check("b2b_drained", longint'(exp_q.size()), 0);
    bus.sampleValid = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    rst = 1'b0;
    step();                                   // T'+4
    check("abort_busy",    longint'(bus.busy), 0);
    check("abort_dataOut", longint'(bus.dataOut), 0);
    check("abort_valid",   longint'(bus.dataOutValid), 0);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) step();
    check("abort_idle", longint'(bus.busy), 0);

    check("valid_count", longint'(valid_seen), longint'(pushed));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
